// File: rtl/bcd_seq_add_ctrl.sv
// Sequential packed-BCD adder: one shared 4-digit adder walks CHUNKS 16-bit chunks, LS chunk first.
// Optional subtract mode (ten's complement) is built when BCD_SUB_EN is defined.

module bcdadd4 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);
    logic [4:0] digit_sum;
    logic       carry;

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        sum       = '0;
        digit_sum = '0;
        carry     = cin;
        for (int i = 0; i < 4; i++) begin
            digit_sum = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0000, carry};
            if (digit_sum > 5'd9) begin
                sum[4*i +: 4] = digit_sum[3:0] + 4'd6;
                carry         = 1'b1;
            end else begin
                sum[4*i +: 4] = digit_sum[3:0];
                carry         = 1'b0;
            end
        end
        cout = carry;
    end
endmodule

module bcd_seq_add_ctrl #(
    parameter int CHUNKS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef BCD_SUB_EN
    input  logic                 sub,
`endif
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [16*CHUNKS-1:0] a,
    input  logic [16*CHUNKS-1:0] b,
    input  logic                 cin,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [16*CHUNKS-1:0] sum,
    output logic                 cout,
    output logic                 busy
);
    localparam int W     = 16 * CHUNKS;
    localparam int IDX_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       a_q, b_q, sum_q;
    logic [IDX_W-1:0]   idx_q;
    logic               carry_q, cout_q, out_valid_q;
    logic [15:0]        a_chunk, b_chunk, b_eff, add_sum;
    logic               add_cout, last_chunk;

    assign a_chunk    = a_q[{idx_q, 4'b0000} +: 16];
    assign b_chunk    = b_q[{idx_q, 4'b0000} +: 16];
    assign last_chunk = (idx_q == IDX_W'(CHUNKS - 1));

`ifdef BCD_SUB_EN
    logic sub_q;

    // Subtract adds the per-digit nines' complement of B with an initial carry of 1.
    always_comb begin
        b_eff = b_chunk;
        if (sub_q) begin
            for (int i = 0; i < 4; i++) b_eff[4*i +: 4] = 4'd9 - b_chunk[4*i +: 4];
        end
    end
`else
    assign b_eff = b_chunk;
`endif

    bcdadd4 u_add (
        .a    (a_chunk),
        .b    (b_eff),
        .cin  (carry_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (in_valid)                  state_d = RUN;
            RUN:  if (last_chunk)                state_d = DONE;
            DONE: if (out_valid_q && out_ready)  state_d = IDLE;
            default:                             state_d = IDLE;
        endcase
    end

    // NOTE: operand and result registers are few and wide, so they are reset like any control flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef BCD_SUB_EN
            sub_q       <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: if (in_valid) begin
                    a_q   <= a;
                    b_q   <= b;
                    idx_q <= '0;
`ifdef BCD_SUB_EN
                    sub_q   <= sub;
                    carry_q <= sub ? 1'b1 : cin;
`else
                    carry_q <= cin;
`endif
                end
                RUN: begin
                    sum_q[{idx_q, 4'b0000} +: 16] <= add_sum;
                    carry_q                       <= add_cout;
                    if (last_chunk) cout_q <= add_cout;
                    else            idx_q  <= idx_q + 1'b1;
                end
                DONE: begin
                    // out_valid is registered, rising one clock after the last chunk lands.
                    if (!out_valid_q)   out_valid_q <= 1'b1;
                    else if (out_ready) out_valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
endmodule

// File: tb/tb_bcd_seq_add_ctrl.sv
// Self-checking bench for bcd_seq_add_ctrl (CHUNKS=4): vector table, corner sequences, random regression.
// Expected results come from the table constants or a binary-integer decimal model through a scoreboard.

module tb_bcd_seq_add_ctrl;
    localparam int CHUNKS = 4;
    localparam int W      = 16 * CHUNKS;
    localparam longint unsigned TEN16 = 64'd10000000000000000;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, cin;
    logic [W-1:0] a, b, sum;
    logic         out_valid, cout, busy;
    logic         out_ready = 1'b0;
`ifdef BCD_SUB_EN
    logic         sub;
`endif

    bcd_seq_add_ctrl #(.CHUNKS(CHUNKS)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef BCD_SUB_EN
        .sub       (sub),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
    } vec_t;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
    } res_t;

    res_t sb[$];
    vec_t tbl[$];
    int   total = 0;
    int   bad   = 0;
    int   rdy_mode = 0;   // 0: always ready, 1: random stalls, 2: held low
    res_t mon_exp;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic longint unsigned bcd2bin(input logic [W-1:0] x);
        longint unsigned r = 0;
        for (int i = 15; i >= 0; i--) r = r * 10 + longint'(x[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] bin2bcd(input longint unsigned v);
        logic [W-1:0] x = '0;
        for (int i = 0; i < 16; i++) begin
            x[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return x;
    endfunction

    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input logic s);
        longint unsigned ax = bcd2bin(x);
        longint unsigned by = bcd2bin(y);
        longint unsigned t;
        res_t r;
        if (s) begin
            t      = ax + (TEN16 - by);
            r.cout = (ax >= by);
        end else begin
            t      = ax + by + longint'(c);
            r.cout = (t >= TEN16);
        end
        r.sum = bin2bcd(t % TEN16);
        return r;
    endfunction

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] x = '0;
        for (int i = 0; i < 16; i++) x[4*i +: 4] = 4'($urandom_range(0, 9));
        return x;
    endfunction

    // Consumer and scoreboard: out_ready chosen at negedge, result compared when the handshake will fire.
    always @(negedge clk) begin
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
        endcase
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL extra_result: got sum %h with no pending accept", sum);
            end else begin
                mon_exp = sb.pop_front();
                check("sum", sum, mon_exp.sum);
                check("cout", W'(cout), W'(mon_exp.cout));
            end
        end
    end

    task automatic send(input vec_t v);
        int n = 0;
        @(negedge clk);
        a   = v.a;
        b   = v.b;
        cin = v.cin;
`ifdef BCD_SUB_EN
        sub = v.sub;
`endif
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: in_ready low for %0d cycles, required 1", n);
            in_valid = 1'b0;
            return;
        end
        sb.push_back('{v.exp_sum, v.exp_cout});
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0 || busy) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: pending=%0d busy=%0d, required 0/0", sb.size(), busy);
            sb.delete();
        end
    endtask

    initial begin
        vec_t v;
        res_t r;
        int   n;

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef BCD_SUB_EN
        sub = 1'b0;
`endif
        tbl.push_back('{64'h0000_0000_0000_9999, 64'h0000_0000_0000_0001, 1'b0, 1'b0, 64'h0000_0000_0001_0000, 1'b0});
        tbl.push_back('{64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 1'b1, 1'b0, 64'h0000_0000_0000_0001, 1'b0});
        tbl.push_back('{64'h5000_0000_0000_0000, 64'h5000_0000_0000_0000, 1'b0, 1'b0, 64'h0000_0000_0000_0000, 1'b1});
        tbl.push_back('{64'h1234_5678_9012_3456, 64'h8765_4321_0987_6543, 1'b0, 1'b0, 64'h9999_9999_9999_9999, 1'b0});
        tbl.push_back('{64'h0000_0000_9999_9999, 64'h0000_0000_0000_0001, 1'b0, 1'b0, 64'h0000_0001_0000_0000, 1'b0});
        tbl.push_back('{64'h0000_9999_9999_9999, 64'h0000_0000_0000_0001, 1'b1, 1'b0, 64'h0001_0000_0000_0001, 1'b0});
`ifdef BCD_SUB_EN
        tbl.push_back('{64'h0000_0000_0000_0100, 64'h0000_0000_0000_0001, 1'b0, 1'b1, 64'h0000_0000_0000_0099, 1'b1});
        tbl.push_back('{64'h0000_0000_0000_0001, 64'h0000_0000_0000_0002, 1'b0, 1'b1, 64'h9999_9999_9999_9999, 1'b0});
        tbl.push_back('{64'h0000_0000_0000_0001, 64'h0000_0000_0000_0002, 1'b1, 1'b0, 64'h0000_0000_0000_0004, 1'b0});
`endif

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_in_ready", W'(in_ready), W'(1));
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_sum", sum, '0);
        check("rst_cout", W'(cout), W'(0));
        check("rst_busy", W'(busy), W'(0));

        for (int i = 0; i < tbl.size(); i++) begin
            send(tbl[i]);
            if (i == 0) begin
                n = 0;
                while (!out_valid && n < 20) begin
                    @(posedge clk);
                    #1 n++;
                end
                check("latency", W'(n), W'(5));
            end
            wait_idle();
        end

        // Consumer stall: result and handshake outputs hold while out_ready stays low.
        rdy_mode = 2;
        send('{64'h9999_9999_9999_9999, 64'h9999_9999_9999_9999, 1'b1, 1'b0, 64'h9999_9999_9999_9999, 1'b1});
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (3) begin
            @(negedge clk);
            check("stall_out_valid", W'(out_valid), W'(1));
            check("stall_sum", sum, 64'h9999_9999_9999_9999);
            check("stall_cout", W'(cout), W'(1));
            check("stall_in_ready", W'(in_ready), W'(0));
        end
        rdy_mode = 0;
        wait_idle();

        // New operands offered during RUN and DONE must be ignored.
        rdy_mode = 2;
        send('{64'h0000_0000_0000_0123, 64'h0000_0000_0000_0456, 1'b0, 1'b0, 64'h0000_0000_0000_0579, 1'b0});
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a = 64'h7777_7777_7777_7777;
            b = 64'h1111_1111_1111_1111;
            check("busy_in_ready", W'(in_ready), W'(0));
        end
        in_valid = 1'b0;
        rdy_mode = 0;
        wait_idle();
        send('{64'h7777_7777_7777_7777, 64'h1111_1111_1111_1111, 1'b0, 1'b0, 64'h8888_8888_8888_8888, 1'b0});
        wait_idle();

        // Reset on the second RUN cycle discards the partial result.
        send('{64'h0000_0000_0000_1234, 64'h0000_0000_0000_0001, 1'b0, 1'b0, 64'h0000_0000_0000_1235, 1'b0});
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        check("midrst_in_ready", W'(in_ready), W'(1));
        check("midrst_out_valid", W'(out_valid), W'(0));
        check("midrst_sum", sum, '0);
        check("midrst_cout", W'(cout), W'(0));
        check("midrst_busy", W'(busy), W'(0));
        send('{64'h0000_0000_0000_0005, 64'h0000_0000_0000_0005, 1'b0, 1'b0, 64'h0000_0000_0000_0010, 1'b0});
        wait_idle();

        // Random regression against the decimal model with producer gaps and consumer stalls.
        rdy_mode = 1;
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            v.a   = rand_bcd();
            v.b   = rand_bcd();
            v.cin = 1'($urandom_range(0, 1));
`ifdef BCD_SUB_EN
            v.sub = 1'($urandom_range(0, 1));
`else
            v.sub = 1'b0;
`endif
            r = model(v.a, v.b, v.cin, v.sub);
            v.exp_sum  = r.sum;
            v.exp_cout = r.cout;
            send(v);
        end
        wait_idle();
        rdy_mode = 0;

        check("pending_results", W'(sb.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
